// File: rtl/conv_accumulator_pkg.sv
// conv_accumulator_pkg
// Shared definitions for the convolution accumulator slice.
//   CONV_ALU_OP    ALU opcode whose Result carries partial convolution sums
//   SAT_MAX/MIN    32-bit signed saturation bounds applied to finished pixels
//   DEFAULT_*      default accumulator width and output FIFO depth
//   acc_state_t    accumulator FSM states
//   pixel_t        one FIFO entry: saturation flag plus pixel value
package conv_accumulator_pkg;

    localparam logic [2:0]  CONV_ALU_OP   = 3'b111;
    localparam logic [31:0] SAT_MAX       = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN       = 32'h8000_0000;
    localparam int          DEFAULT_ACC_W = 40;
    localparam int          DEFAULT_DEPTH = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } acc_state_t;

    typedef struct packed {
        logic        sat;
        logic [31:0] data;
    } pixel_t;

    // A configured length of zero still means one partial per pixel.
    function automatic logic [3:0] effective_len(input logic [3:0] len);
        return (len == 4'd0) ? 4'd1 : len;
    endfunction

endpackage

// File: rtl/conv_accumulator_sync_fifo.sv
// sync_fifo
// Single-clock FIFO holding finished pixels until the writeback stage takes them.
//   clk, rst     clock and asynchronous active-low reset
//   flush        synchronous empty; wins over a same-cycle push or pop
//   push, wdata  write request (ignored when full)
//   pop, rdata   read request (ignored when empty); rdata shows the head entry
//   full, empty  occupancy flags
//   count        number of occupied entries
module sync_fifo
    import conv_accumulator_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PW'(1);
            if (do_pop)  rptr_d = rptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted as occupied.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/conv_accumulator.sv
// conv_accumulator
// Sums cfg_len consecutive 32-bit signed partial convolution sums into one pixel,
// saturates to 32 bits, optionally applies ReLU and queues the pixel for writeback.
//   clk, rst            clock and asynchronous active-low reset
//   clear               synchronous flush of partial sum, beat count and FIFO
//   cfg_len, cfg_relu   group length (0 means 1) and ReLU enable, latched on a group's first beat
//   in_valid/in_ready   input handshake, in_data is the partial sum
//   out_valid/out_ready output handshake, out_data/out_sat describe the FIFO head
//   busy                a group is partially accumulated
//   fifo_cnt            occupied FIFO entries
module conv_accumulator
    import conv_accumulator_pkg::*;
#(
    parameter int ACC_W = DEFAULT_ACC_W,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [3:0]             cfg_len,
    input  logic                   cfg_relu,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic                   out_sat,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_cnt
);

    localparam logic signed [ACC_W-1:0] SUM_MAX = ACC_W'($signed(SAT_MAX));
    localparam logic signed [ACC_W-1:0] SUM_MIN = ACC_W'($signed(SAT_MIN));

    acc_state_t              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [3:0]              len_q, len_d;
    logic                    relu_q, relu_d;

    logic signed [ACC_W-1:0] beat_ext;
    logic signed [ACC_W-1:0] fin_sum;
    logic                    fin_relu;
    logic                    push;
    pixel_t                  fin_pix;
    pixel_t                  head_pix;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    accept;
    logic [3:0]              first_len;

    // The FIFO-full term is deliberately applied to every beat, even non-final ones.
    assign in_ready  = ~fifo_full & ~clear;
    assign accept    = in_valid & in_ready;
    assign beat_ext  = ACC_W'($signed(in_data));
    assign first_len = effective_len(cfg_len);
    assign busy      = (state_q == ST_ACC);
    assign out_valid = ~fifo_empty;
    assign out_data  = out_valid ? head_pix.data : '0;
    assign out_sat   = out_valid & head_pix.sat;

    // Group sequencing: the first beat latches the configuration, the beat that
    // completes the group hands its sum to the finalize logic for a same-cycle push.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        relu_d   = relu_q;
        push     = 1'b0;
        fin_sum  = beat_ext;
        fin_relu = relu_q;
        if (clear) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    len_d  = first_len;
                    relu_d = cfg_relu;
                    if (first_len == 4'd1) begin
                        push     = 1'b1;
                        fin_sum  = beat_ext;
                        fin_relu = cfg_relu;
                    end else begin
                        acc_d   = beat_ext;
                        cnt_d   = 4'd1;
                        state_d = ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (cnt_q + 4'd1 == len_q) begin
                        push    = 1'b1;
                        fin_sum = acc_q + beat_ext;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        acc_d = acc_q + beat_ext;
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ReLU acts on the already-saturated value, so a negative clamp keeps its sat flag.
    always_comb begin
        fin_pix.sat  = 1'b0;
        fin_pix.data = fin_sum[31:0];
        if (fin_sum > SUM_MAX) begin
            fin_pix.sat  = 1'b1;
            fin_pix.data = SAT_MAX;
        end else if (fin_sum < SUM_MIN) begin
            fin_pix.sat  = 1'b1;
            fin_pix.data = SAT_MIN;
        end
        if (fin_relu && fin_pix.data[31]) fin_pix.data = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= 4'd1;
            relu_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            relu_q  <= relu_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(pixel_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clear),
        .push  (push),
        .wdata (fin_pix),
        .pop   (out_valid & out_ready),
        .rdata (head_pix),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

endmodule

// File: tb/tb_conv_accumulator.sv
// tb_conv_accumulator
// Scoreboard bench: a reference model turns accepted beats into expected pixels,
// and a monitor compares them against every pixel the DUT hands over.
module tb_conv_accumulator;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [3:0]  cfg_len;
    logic        cfg_relu;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic        busy;
    logic [2:0]  fifo_cnt;

    int tests = 0;
    int fails = 0;

    logic [32:0] expQ[$];
    int          grp[$];
    int          mlen = 1;
    bit          mrelu = 1'b0;

    conv_accumulator #(.ACC_W(40), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .cfg_len   (cfg_len),
        .cfg_relu  (cfg_relu),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .busy      (busy),
        .fifo_cnt  (fifo_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pixel rule written straight from the arithmetic: exact sum, clamp, then ReLU.
    function automatic logic [32:0] refPixel(input longint sum, input bit relu);
        longint v;
        bit     sat;
        v   = sum;
        sat = 1'b0;
        if (v > 64'sd2147483647) begin
            v   = 64'sd2147483647;
            sat = 1'b1;
        end else if (v < -64'sd2147483648) begin
            v   = -64'sd2147483648;
            sat = 1'b1;
        end
        if (relu && v < 0) v = 0;
        return {sat, v[31:0]};
    endfunction

    // Monitor and model share the falling edge: the head is compared before this
    // cycle's accepted beat is folded into the model.
    always @(negedge clk) begin
        longint     sum;
        logic [32:0] exp;
        if (!rst) begin
            expQ.delete();
            grp.delete();
        end else begin
            if (out_valid && out_ready && !clear) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_pixel", {31'd0, out_sat, out_data}, 64'h1_dead_beef);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("pixel", {31'd0, out_sat, out_data}, {31'd0, exp});
                end
            end
            if (clear) begin
                expQ.delete();
                grp.delete();
            end else if (in_valid && in_ready) begin
                if (grp.size() == 0) begin
                    mlen  = (cfg_len == 4'd0) ? 1 : int'(cfg_len);
                    mrelu = cfg_relu;
                end
                grp.push_back($signed(in_data));
                if (grp.size() == mlen) begin
                    sum = 0;
                    foreach (grp[i]) sum += longint'(grp[i]);
                    expQ.push_back(refPixel(sum, mrelu));
                    grp.delete();
                end
            end
        end
    end

    // Offers one beat and holds it until accepted, within a cycle budget.
    task automatic applyStimulus(input logic [31:0] d, input logic [3:0] len, input logic relu);
        int waitCycles;
        waitCycles = 0;
        in_valid = 1'b1;
        in_data  = d;
        cfg_len  = len;
        cfg_relu = relu;
        @(negedge clk);
        while (!in_ready && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) checkOutput("beat_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        bit done;
        rst       = 1'b0;
        clear     = 1'b0;
        cfg_len   = 4'd0;
        cfg_relu  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        #12;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_out_sat", 64'(out_sat), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_fifo_cnt", 64'(fifo_cnt), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;

        // Three-beat group with one-cycle output latency.
        applyStimulus(32'd10, 4'd3, 1'b0);
        checkOutput("t1_busy_mid", 64'(busy), 64'd1);
        applyStimulus(-32'sd4, 4'd3, 1'b0);
        applyStimulus(32'd7, 4'd3, 1'b0);
        checkOutput("t1_latency_valid", 64'(out_valid), 64'd1);
        checkOutput("t1_data", 64'(out_data), 64'd13);
        checkOutput("t1_busy_done", 64'(busy), 64'd0);
        idleCycles(2);

        // Positive and negative saturation.
        applyStimulus(32'h7000_0000, 4'd2, 1'b0);
        applyStimulus(32'h7000_0000, 4'd2, 1'b0);
        checkOutput("t2_pos_sat", {31'd0, out_sat, out_data}, {31'd0, 1'b1, 32'h7FFF_FFFF});
        idleCycles(2);
        applyStimulus(32'h9000_0000, 4'd2, 1'b0);
        applyStimulus(32'h9000_0000, 4'd2, 1'b0);
        checkOutput("t2_neg_sat", {31'd0, out_sat, out_data}, {31'd0, 1'b1, 32'h8000_0000});
        idleCycles(2);

        // ReLU and zero length.
        applyStimulus(-32'sd5, 4'd2, 1'b1);
        applyStimulus(32'd2, 4'd2, 1'b0);
        checkOutput("t3_relu", {31'd0, out_sat, out_data}, 64'd0);
        idleCycles(2);
        applyStimulus(32'd9, 4'd0, 1'b0);
        checkOutput("t3_len0", {31'd0, out_sat, out_data}, 64'd9);
        idleCycles(2);

        // Backpressure fills the FIFO, then drains in order.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(32'd100 + 32'(i), 4'd1, 1'b0);
        checkOutput("t4_full_in_ready", 64'(in_ready), 64'd0);
        checkOutput("t4_full_cnt", 64'(fifo_cnt), 64'd4);
        idleCycles(2);
        checkOutput("t4_hold_data", 64'(out_data), 64'd100);
        out_ready = 1'b1;
        applyStimulus(32'd104, 4'd1, 1'b0);
        applyStimulus(32'd105, 4'd1, 1'b0);
        idleCycles(8);
        checkOutput("t4_drained", 64'(fifo_cnt), 64'd0);

        // Clear drops a partial group and buffered pixels.
        out_ready = 1'b0;
        applyStimulus(32'd77, 4'd1, 1'b0);
        applyStimulus(32'd1, 4'd4, 1'b0);
        applyStimulus(32'd1, 4'd4, 1'b0);
        checkOutput("t5_busy_before", 64'(busy), 64'd1);
        checkOutput("t5_cnt_before", 64'(fifo_cnt), 64'd1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        checkOutput("t5_busy_after", 64'(busy), 64'd0);
        checkOutput("t5_cnt_after", 64'(fifo_cnt), 64'd0);
        checkOutput("t5_valid_after", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(32'd1, 4'd4, 1'b0);
        checkOutput("t5_sum", 64'(out_data), 64'd4);
        idleCycles(2);

        // Asynchronous reset mid-group with pixels buffered.
        out_ready = 1'b0;
        applyStimulus(32'd11, 4'd1, 1'b0);
        applyStimulus(32'd12, 4'd1, 1'b0);
        applyStimulus(32'd3, 4'd3, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_valid", 64'(out_valid), 64'd0);
        checkOutput("t6_data", 64'(out_data), 64'd0);
        checkOutput("t6_busy", 64'(busy), 64'd0);
        checkOutput("t6_cnt", 64'(fifo_cnt), 64'd0);
        checkOutput("t6_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        applyStimulus(32'd5, 4'd2, 1'b0);
        applyStimulus(32'd6, 4'd2, 1'b0);
        checkOutput("t6_fresh_group", 64'(out_data), 64'd11);
        idleCycles(2);

        // Randomized traffic with random backpressure and mid-group config changes.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    logic [31:0] d;
                    d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
                    applyStimulus(d, 4'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 7) == 0) idleCycles($urandom_range(1, 3));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (expQ.size() != 0 || out_valid); i++) @(negedge clk);
        checkOutput("random_drained_queue", 64'(expQ.size()), 64'd0);
        checkOutput("random_drained_cnt", 64'(fifo_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
